// File: rtl/exe_pkg.sv
// Shared encodings and types for the execute stage and its multiply/divide unit.
package exe_pkg;

  // ALU opcodes (exe_cmd)
  localparam logic [3:0] EXE_ADD  = 4'd0;
  localparam logic [3:0] EXE_SUB  = 4'd2;
  localparam logic [3:0] EXE_AND  = 4'd4;
  localparam logic [3:0] EXE_OR   = 4'd5;
  localparam logic [3:0] EXE_NOR  = 4'd6;
  localparam logic [3:0] EXE_XOR  = 4'd7;
  localparam logic [3:0] EXE_SLL  = 4'd8;
  localparam logic [3:0] EXE_SRA  = 4'd9;
  localparam logic [3:0] EXE_SRL  = 4'd10;
  localparam logic [3:0] EXE_SLT  = 4'd11;
  localparam logic [3:0] EXE_SLTU = 4'd12;

  // Branch opcodes (br_type); 6 and 7 behave as BR_NONE
  localparam logic [2:0] BR_NONE = 3'd0;
  localparam logic [2:0] BR_BEQ  = 3'd1;
  localparam logic [2:0] BR_BNE  = 3'd2;
  localparam logic [2:0] BR_JMP  = 3'd3;
  localparam logic [2:0] BR_BLTZ = 3'd4;
  localparam logic [2:0] BR_BGEZ = 3'd5;

  // Multiply/divide opcodes (md_op); 5..7 behave as MD_NONE
  localparam logic [2:0] MD_NONE  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIVU  = 3'd2;
  localparam logic [2:0] MD_MFHI  = 3'd3;
  localparam logic [2:0] MD_MFLO  = 3'd4;

  // Forwarding select codes; 3 also selects the register value
  localparam logic [1:0] FWD_REG = 2'd0;
  localparam logic [1:0] FWD_MEM = 2'd1;
  localparam logic [1:0] FWD_WB  = 2'd2;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_MUL  = 2'd1,
    MD_DIV  = 2'd2,
    MD_DONE = 2'd3
  } md_state_e;

  // True for the opcodes that launch an iterative operation
  function automatic logic is_md_start(input logic [2:0] op);
    return (op == MD_MULTU) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/exe_stage_md_md_unit.sv
// Iterative unsigned multiply/divide unit owning HI/LO.
//
// state   | meaning
// --------+----------------------------------------------------------
// MD_IDLE | waiting; MULTU/DIVU latches operands and stalls this cycle
// MD_MUL  | shift-add multiply, one multiplier bit per cycle
// MD_DIV  | restoring divide, one quotient bit per cycle (or /0 shortcut)
// MD_DONE | HI/LO updated, stall released, md_op ignored for one cycle
module md_unit
  import exe_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       md_op,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             md_stall,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  md_state_e        state, state_nxt;
  logic [CNT_W-1:0] cnt;
  // acc_hi: partial product high half / partial remainder
  // acc_lo: multiplier being shifted out / dividend in, quotient out
  logic [WIDTH-1:0] acc_hi, acc_lo;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] hi_q, lo_q;

  logic             start, last, div_zero;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi_nxt, mul_lo_nxt;
  logic [WIDTH:0]   div_sh;
  logic             div_ok;
  logic [WIDTH-1:0] div_diff, div_rem_nxt, div_q_nxt;

  assign start    = (state == MD_IDLE) && is_md_start(md_op);
  assign last     = (cnt == CNT_W'(WIDTH - 1));
  assign div_zero = (opb == '0);
  assign hi       = hi_q;
  assign lo       = lo_q;

  // One iteration step of each algorithm, from the current accumulators
  always_comb begin
    mul_sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : '0);
    mul_hi_nxt  = mul_sum[WIDTH:1];
    mul_lo_nxt  = {mul_sum[0], acc_lo[WIDTH-1:1]};
    div_sh      = {acc_hi, acc_lo[WIDTH-1]};
    div_ok      = (div_sh >= {1'b0, opb});
    // Only used when div_ok, where the true difference fits in WIDTH bits
    div_diff    = div_sh[WIDTH-1:0] - opb;
    div_rem_nxt = div_ok ? div_diff : div_sh[WIDTH-1:0];
    div_q_nxt   = {acc_lo[WIDTH-2:0], div_ok};
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= MD_IDLE;
    else     state <= state_nxt;
  end

  // Next-state and stall decode
  always_comb begin
    state_nxt = state;
    md_stall  = 1'b0;
    case (state)
      MD_IDLE: begin
        if (start) begin
          md_stall  = 1'b1;
          state_nxt = (md_op == MD_MULTU) ? MD_MUL : MD_DIV;
        end
      end
      MD_MUL: begin
        md_stall = 1'b1;
        if (last) state_nxt = MD_DONE;
      end
      MD_DIV: begin
        md_stall = 1'b1;
        if (div_zero || last) state_nxt = MD_DONE;
      end
      MD_DONE: state_nxt = MD_IDLE;
      default: state_nxt = MD_IDLE;
    endcase
  end

  // Operand latch, iteration datapath, counter and HI/LO writeback
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      opb    <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      case (state)
        MD_IDLE: begin
          if (start) begin
            cnt    <= '0;
            acc_hi <= '0;
            acc_lo <= op_a;
            opb    <= op_b;
          end
        end
        MD_MUL: begin
          acc_hi <= mul_hi_nxt;
          acc_lo <= mul_lo_nxt;
          cnt    <= cnt + 1'b1;
          if (last) begin
            hi_q <= mul_hi_nxt;
            lo_q <= mul_lo_nxt;
          end
        end
        MD_DIV: begin
          if (div_zero) begin
            hi_q <= acc_lo;
            lo_q <= '1;
          end else begin
            acc_hi <= div_rem_nxt;
            acc_lo <= div_q_nxt;
            cnt    <= cnt + 1'b1;
            if (last) begin
              hi_q <= div_rem_nxt;
              lo_q <= div_q_nxt;
            end
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

endmodule

// File: rtl/exe_stage_md.sv
// Execute stage: forwarding muxes, ALU, branch resolution/target and MUL/DIV.
module exe_stage_md
  import exe_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       sel_val1,
  input  logic [1:0]       sel_val2,
  input  logic [1:0]       sel_src2,
  input  logic [3:0]       exe_cmd,
  input  logic [2:0]       br_type,
  input  logic [2:0]       md_op,
  input  logic [WIDTH-1:0] val1,
  input  logic [WIDTH-1:0] val2,
  input  logic [WIDTH-1:0] val_src2,
  input  logic [WIDTH-1:0] mem_fwd,
  input  logic [WIDTH-1:0] wb_fwd,
  input  logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] alu_result,
  output logic [WIDTH-1:0] br_addr,
  output logic             br_taken,
  output logic             md_stall,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int SH_W = CNT_W - 1;

  logic [WIDTH-1:0] op1, op2, src2, alu_out;
  logic [SH_W-1:0]  shamt;

  // Forwarding muxes
  always_comb begin
    case (sel_val1)
      FWD_MEM: op1 = mem_fwd;
      FWD_WB:  op1 = wb_fwd;
      default: op1 = val1;
    endcase
    case (sel_val2)
      FWD_MEM: op2 = mem_fwd;
      FWD_WB:  op2 = wb_fwd;
      default: op2 = val2;
    endcase
    case (sel_src2)
      FWD_MEM: src2 = mem_fwd;
      FWD_WB:  src2 = wb_fwd;
      default: src2 = val_src2;
    endcase
  end

  assign shamt = op2[SH_W-1:0];

  // ALU
  always_comb begin
    alu_out = '0;
    case (exe_cmd)
      EXE_ADD:  alu_out = op1 + op2;
      EXE_SUB:  alu_out = op1 - op2;
      EXE_AND:  alu_out = op1 & op2;
      EXE_OR:   alu_out = op1 | op2;
      EXE_NOR:  alu_out = ~(op1 | op2);
      EXE_XOR:  alu_out = op1 ^ op2;
      EXE_SLL:  alu_out = op1 << shamt;
      EXE_SRA:  alu_out = $signed(op1) >>> shamt;
      EXE_SRL:  alu_out = op1 >> shamt;
      EXE_SLT:  alu_out = {{(WIDTH-1){1'b0}}, ($signed(op1) < $signed(op2))};
      EXE_SLTU: alu_out = {{(WIDTH-1){1'b0}}, (op1 < op2)};
      default:  alu_out = '0;
    endcase
  end

  // Result select: HI/LO moves bypass the ALU
  always_comb begin
    case (md_op)
      MD_MFHI: alu_result = hi;
      MD_MFLO: alu_result = lo;
      default: alu_result = alu_out;
    endcase
  end

  // Branch condition
  always_comb begin
    case (br_type)
      BR_BEQ:  br_taken = (op1 == src2);
      BR_BNE:  br_taken = (op1 != src2);
      BR_JMP:  br_taken = 1'b1;
      BR_BLTZ: br_taken = op1[WIDTH-1];
      BR_BGEZ: br_taken = ~op1[WIDTH-1];
      default: br_taken = 1'b0;
    endcase
  end

  assign br_addr = pc + op2;

  md_unit #(.WIDTH(WIDTH)) u_md_unit (
    .clk      (clk),
    .rst      (rst),
    .md_op    (md_op),
    .op_a     (op1),
    .op_b     (op2),
    .md_stall (md_stall),
    .hi       (hi),
    .lo       (lo)
  );

endmodule
